nx1_mux_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the N:1 single-bit multiplexer datapath. N requesters each raise a request. The block picks one winner fairly and drives the mux select, a one-hot grant and a registered snapshot of the selected input bit. It then holds that result under a valid/ready handshake until the downstream consumer accepts it. It sits between the requesting sources and the shared `nx1_mux` select path, so the mux select is never driven by more than one owner.

---
 rtl/nx1_mux_rr_arbiter.sv | 116 +++++++++++
 tb/tb_nx1_mux_rr_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nx1_mux_rr_arbiter.sv
// nx1_mux_rr_arbiter
//   Round-robin arbiter and sequencer for the N:1 single-bit mux datapath.
//   It picks one requester fairly and registers the mux select, a one-hot
//   grant and a snapshot of the selected data bit. The result is then held
//   under a valid/ready handshake until the consumer accepts it.
//
// Parameters
//   N      number of requesters / mux inputs (>= 2, any value)
//   SEL_W  select width, clog2(N)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester request level
//   in         mux data inputs, bit i belongs to requester i
//   out_ready  downstream accepts the current result
//   sel        registered select = current winner index
//   gnt        registered one-hot grant, zero when idle
//   out_valid  registered, result on out_data/sel is valid
//   out_data   registered snapshot of in[sel] taken at grant time
//   ack        combinational one-hot transfer-done pulse
//   busy       registered, high while a result is held
module nx1_mux_rr_arbiter #(
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     in,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             out_valid,
  output logic             out_data,
  output logic [N-1:0]     ack,
  output logic             busy
);

  localparam int unsigned NU = N;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;

  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic [N-1:0]     win_onehot;
  int unsigned      scan_idx;

  // Scan from ptr upward with an explicit modulo-N wrap, so a non power of
  // two N never aliases onto indices beyond N-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NU) begin
        scan_idx = scan_idx - NU;
      end
      if (!win_found && req[scan_idx[SEL_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            sel       <= win_idx;
            gnt       <= win_onehot;
            out_data  <= in[win_idx];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // req and in are ignored here; only the handshake releases the grant.
          if (out_valid && out_ready) begin
            ptr       <= (sel == SEL_W'(N - 1)) ? '0 : sel + 1'b1;
            gnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ack = gnt & {N{out_valid & out_ready}};

endmodule

// File: tb/tb_nx1_mux_rr_arbiter.sv
// Testbench for nx1_mux_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural round-robin model.
module tb_nx1_mux_rr_arbiter;

  localparam int N     = 16;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N-1:0]     in;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     gnt;
  logic             out_valid;
  logic             out_data;
  logic [N-1:0]     ack;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  nx1_mux_rr_arbiter #(.N(N), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in(in), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .out_valid(out_valid), .out_data(out_data),
    .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: holding flag, winner index, captured bit, pointer.
  bit m_hold = 0;
  int m_w    = 0;
  bit m_data = 0;
  int m_ptr  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_w = 0; m_data = 0; m_ptr = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        m_ptr  = (m_w + 1) % N;
      end
    end else if (req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (!m_hold && req[(m_ptr + k) % N]) begin
          m_w    = (m_ptr + k) % N;
          m_data = in[m_w];
          m_hold = 1;
        end
      end
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] e_gnt;
      e_gnt = m_hold ? (N'(1) << m_w) : '0;
      check("model_valid", 32'(out_valid), 32'(m_hold));
      check("model_busy",  32'(busy),      32'(m_hold));
      check("model_gnt",   32'(gnt),       32'(e_gnt));
      check("model_sel",   32'(sel),       32'(m_w));
      check("model_data",  32'(out_data),  32'(m_data));
      check("model_ack",   32'(ack),       32'(out_ready ? e_gnt : '0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] last_g;
    int           grants;
    bit           rr_done;

    rst_n = 1'b0; req = '0; in = '0; out_ready = 1'b0;
    #12;
    check("rst_sel",   32'(sel),       32'h0);
    check("rst_gnt",   32'(gnt),       32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    rst_n  = 1'b1;
    cmp_en = 1;

    // Single request
    req = 16'h0040; in = 16'h0040; out_ready = 1'b1;
    tick();
    check("single_sel",   32'(sel),       32'd6);
    check("single_gnt",   32'(gnt),       32'h0040);
    check("single_data",  32'(out_data),  32'h1);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_ack",   32'(ack),       32'h0040);
    req = '0;
    tick();
    check("single_idle_valid", 32'(out_valid), 32'h0);
    check("single_idle_ack",   32'(ack),       32'h0);

    // Reset in the middle of a HOLD
    req = 16'hFFFF; out_ready = 1'b0;
    tick();
    check("hold_sel_ptr7", 32'(sel), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel",   32'(sel),       32'h0);
    check("async_rst_gnt",   32'(gnt),       32'h0);
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_data",  32'(out_data),  32'h0);
    check("async_rst_busy",  32'(busy),      32'h0);
    check("async_rst_ack",   32'(ack),       32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_sel", 32'(sel), 32'd0);
    check("post_rst_gnt", 32'(gnt), 32'h0001);

    // Round robin over all requesters
    out_ready = 1'b1; last_g = '0; grants = 0; rr_done = 0;
    for (int cyc = 0; cyc < 34; cyc++) begin
      check("rr_cadence", 32'(out_valid), 32'((cyc % 2) == 0));
      if (out_valid) begin
        check("rr_sel", 32'(sel), 32'(grants % N));
        grants++;
        last_g = gnt;
        if (grants == N + 1) rr_done = 1;
        req = rr_done ? '0 : 16'hFFFF;
      end else begin
        req = rr_done ? '0 : (16'hFFFF & ~last_g);
      end
      tick();
    end

    // Backpressure (ptr = 1)
    req = 16'h0100; in = 16'h0100; out_ready = 1'b0;
    tick();
    in = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_sel",   32'(sel),       32'd8);
      check("bp_data",  32'(out_data),  32'h1);
      check("bp_ack",   32'(ack),       32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_ack_pulse", 32'(ack), 32'h0100);
    req = '0;
    tick();
    check("bp_done_valid", 32'(out_valid), 32'h0);

    // Wrap (ptr = 9 -> grant 14 -> ptr 15)
    req = 16'h4000;
    tick();
    check("wrap_sel14", 32'(sel), 32'd14);
    req = 16'h8008;
    tick();
    check("wrap_idle", 32'(out_valid), 32'h0);
    tick();
    check("wrap_sel15", 32'(sel), 32'd15);
    req = 16'h0008;
    tick();
    tick();
    check("wrap_sel3", 32'(sel), 32'd3);
    req = 16'hFFFF;
    tick();
    tick();
    check("wrap_ptr4", 32'(sel), 32'd4);
    req = '0;
    tick();

    // Winner drops its request during HOLD (ptr = 5)
    out_ready = 1'b0; req = 16'h0002; in = 16'h0000;
    tick();
    check("drop_sel", 32'(sel), 32'd1);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      check("drop_valid", 32'(out_valid), 32'h1);
      check("drop_gnt",   32'(gnt),       32'h0002);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("drop_ack", 32'(ack), 32'h0002);
    tick();
    check("drop_done", 32'(out_valid), 32'h0);

    // Randomized traffic, model-checked every cycle
    for (int cyc = 0; cyc < 600; cyc++) begin
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = N'($urandom) & N'($urandom) & N'($urandom);
        2: req = N'($urandom);
        default: req = N'(1) << $urandom_range(0, N - 1);
      endcase
      in        = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (cyc == 300) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand_rst_valid", 32'(out_valid), 32'h0);
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
